hmac_msg_packer: RTL

//  Upstream feeder for the HMAC controller's 32-bit message port.
//  - Accepts a host byte stream (valid/ready, last) and packs it little-endian into 32-bit words.
//  - Buffers the words in a small FIFO and presents them as msg_word/msg_valid/msg_last under msg_ready backpressure.
//  - Reports the byte count of the final word and the total message length.

---
 rtl/hmac_pkg.sv | 19 +
 rtl/hmac_msg_packer_if.sv | 26 ++
 rtl/hmac_word_fifo.sv | 80 ++++++++
 rtl/hmac_msg_packer.sv | 117 +++++++++++
 4 files changed

// File: rtl/hmac_pkg.sv
// Shared types and constants for the HMAC message packer and its word FIFO.
package hmac_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic {
    P_IDLE,
    P_FILL
  } pack_state_e;

  typedef struct packed {
    logic              last;
    logic [1:0]        nbytes;
    logic [WORD_W-1:0] word;
  } fifo_entry_t;

endpackage

// File: rtl/hmac_msg_packer_if.sv
// Host byte stream and packed message word stream of the HMAC message packer.
interface hmac_msg_packer_if #(
  parameter int unsigned LEN_W = 32
);
  logic [hmac_pkg::BYTE_W-1:0] in_byte;
  logic                        in_valid;
  logic                        in_last;
  logic                        in_ready;
  logic [hmac_pkg::WORD_W-1:0] msg_word;
  logic                        msg_valid;
  logic                        msg_last;
  logic                        msg_ready;
  logic [1:0]                  msg_last_bytes;
  logic [LEN_W-1:0]            msg_len;
  logic                        msg_len_valid;

  modport master (
    output in_byte, in_valid, in_last, msg_ready,
    input  in_ready, msg_word, msg_valid, msg_last, msg_last_bytes, msg_len, msg_len_valid
  );

  modport slave (
    input  in_byte, in_valid, in_last, msg_ready,
    output in_ready, msg_word, msg_valid, msg_last, msg_last_bytes, msg_len, msg_len_valid
  );
endinterface

// File: rtl/hmac_word_fifo.sv
// Synchronous word FIFO with a registered head entry and a synchronous clear.
module hmac_word_fifo
  import hmac_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        push,
  input  fifo_entry_t wdata,
  input  logic        pop,
  output logic        full,
  output fifo_entry_t head,
  output logic        head_valid
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  fifo_entry_t     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d, remain;
  fifo_entry_t     head_q, head_d;
  logic            valid_q, valid_d;
  logic            do_push, do_pop;

  assign full       = (cnt_q == CntW'(DEPTH));
  assign do_push    = push && !full && !clear;
  assign do_pop     = pop && valid_q && !clear;
  assign head       = head_q;
  assign head_valid = valid_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
    wr_ptr_d = wr_ptr_q + PtrW'(do_push);
    remain   = cnt_q - CntW'(do_pop);
    cnt_d    = remain + CntW'(do_push);
    valid_d  = (cnt_d != '0);
    // Head is the oldest entry left after the pop; an empty FIFO forwards the incoming word.
    if (remain != '0) begin
      head_d = mem_q[rd_ptr_d];
    end else if (do_push) begin
      head_d = wdata;
    end else begin
      head_d = '0;
    end
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      head_d   = '0;
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: rtl/hmac_msg_packer.sv
// Packs a host byte stream into 32-bit HMAC message words and tracks message length.
// Define HMAC_PACK_BSWAP_EN for big-endian lane order (first byte in bits [31:24]).
module hmac_msg_packer
  import hmac_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 32
) (
  input logic               clk,
  input logic               reset_n,
  input logic               abort,
  hmac_msg_packer_if.slave  bus
);

  pack_state_e       state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0] pack_q, pack_d, merged;
  logic [LEN_W-1:0]  count_q, count_d, count_inc;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              len_valid_q, len_valid_d;
  logic              run_q;
  logic              fifo_full, accept, push, head_valid;
  logic [1:0]        lane;
  fifo_entry_t       push_entry, head;

  // run_q keeps in_ready low until the first edge after reset release.
  assign bus.in_ready = run_q && !fifo_full && !abort;
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && ((byte_idx_q == 2'd3) || bus.in_last);

`ifdef HMAC_PACK_BSWAP_EN
  assign lane = 2'd3 - byte_idx_q;
`else
  assign lane = byte_idx_q;
`endif

  always_comb begin
    merged                        = pack_q;
    merged[{lane, 3'b000} +: BYTE_W] = bus.in_byte;
  end

  assign push_entry = '{last: bus.in_last, nbytes: byte_idx_q + 2'd1, word: merged};
  assign count_inc  = (count_q == '1) ? count_q : count_q + LEN_W'(1);

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    pack_d      = pack_q;
    count_d     = count_q;
    len_d       = len_q;
    len_valid_d = 1'b0;
    if (abort) begin
      state_d    = P_IDLE;
      byte_idx_d = '0;
      pack_d     = '0;
      count_d    = '0;
    end else if (accept) begin
      count_d = count_inc;
      if (push) begin
        byte_idx_d = '0;
        pack_d     = '0;
      end else begin
        byte_idx_d = byte_idx_q + 2'd1;
        pack_d     = merged;
      end
      // Either state closes the message on in_last and stays open otherwise.
      state_d = bus.in_last ? P_IDLE : P_FILL;
      if (bus.in_last) begin
        len_d       = count_inc;
        len_valid_d = 1'b1;
        count_d     = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= P_IDLE;
      byte_idx_q  <= '0;
      pack_q      <= '0;
      count_q     <= '0;
      len_q       <= '0;
      len_valid_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      pack_q      <= pack_d;
      count_q     <= count_d;
      len_q       <= len_d;
      len_valid_q <= len_valid_d;
      run_q       <= 1'b1;
    end
  end

  hmac_word_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (abort),
    .push      (push),
    .wdata     (push_entry),
    .pop       (bus.msg_ready),
    .full      (fifo_full),
    .head      (head),
    .head_valid(head_valid)
  );

  assign bus.msg_word       = head.word;
  assign bus.msg_last       = head.last;
  assign bus.msg_last_bytes = head.nbytes;
  assign bus.msg_valid      = head_valid;
  assign bus.msg_len        = len_q;
  assign bus.msg_len_valid  = len_valid_q;

endmodule
